// File: rtl/code_check_multi.sv
// Keypad code checker: latches a reference code on GO, checks keyed digits
// with sticky mismatch, counts consecutive failures and enforces a timed lockout.
module code_check_multi #(
    parameter int KEY_W       = 4,
    parameter int MAX_LEN     = 6,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     GO,
    input  logic [KEY_W-1:0]         BUTTON,
    input  logic                     BPRESS,
    input  logic [KEY_W*MAX_LEN-1:0] CORRECT_CODE,
    input  logic [3:0]               LENGTH,
    input  logic [KEY_W-1:0]         ENTER_BUTTON,
    input  logic [KEY_W-1:0]         CLEAR_BUTTON,
    output logic                     DONE,
    output logic                     SUCCESS,
    output logic                     LOCKED,
    output logic [3:0]               FAILS
);

    // state    | meaning
    // S_IDLE   | waiting for GO
    // S_ARM    | one dead cycle after GO, key presses ignored
    // S_ENTER  | collecting digits until the enter key
    // S_PASS   | DONE+SUCCESS pulse, failure count cleared
    // S_FAIL   | DONE pulse, failure count bumped
    // S_LOCKOUT| timed lockout, all input ignored
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_ENTER, S_PASS, S_FAIL, S_LOCKOUT
    } state_t;

    state_t                   state_q, state_d;
    logic [KEY_W*MAX_LEN-1:0] code_q, code_d;
    logic [3:0]               len_q, len_d;
    logic [3:0]               idx_q, idx_d;
    logic [3:0]               fails_q, fails_d;
    logic                     mis_q, mis_d;
    logic [TW-1:0]            tmr_q, tmr_d;

    logic [KEY_W-1:0]         cur_digit;
    logic [3:0]               fails_inc;
    logic                     len_ok;

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) cur_digit = code_q[i*KEY_W +: KEY_W];
        end
    end

    assign fails_inc = (fails_q == 4'hF) ? 4'hF : fails_q + 4'd1;
    assign len_ok    = (len_q != 4'd0) && (len_q <= 4'(MAX_LEN));

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        idx_d   = idx_q;
        fails_d = fails_q;
        mis_d   = mis_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (GO) begin
                    code_d  = CORRECT_CODE;
                    len_d   = LENGTH;
                    idx_d   = 4'd0;
                    mis_d   = 1'b0;
                    state_d = S_ARM;
                end
            end
            S_ARM: state_d = S_ENTER;
            S_ENTER: begin
                if (BPRESS) begin
                    if (BUTTON == ENTER_BUTTON) begin
                        state_d = (!mis_q && idx_q == len_q && len_ok) ? S_PASS : S_FAIL;
                    end else if (BUTTON == CLEAR_BUTTON) begin
                        idx_d = 4'd0;
                        mis_d = 1'b0;
                    end else if (idx_q < 4'(MAX_LEN)) begin
                        if (BUTTON != cur_digit) mis_d = 1'b1;
                        idx_d = idx_q + 4'd1;
                    end else begin
                        // too many digits: index saturates, attempt is doomed
                        mis_d = 1'b1;
                    end
                end
            end
            S_PASS: begin
                fails_d = 4'd0;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                fails_d = fails_inc;
                if (fails_inc >= 4'(MAX_TRIES)) begin
                    tmr_d   = TW'(LOCK_CYCLES - 1);
                    state_d = S_LOCKOUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    fails_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            len_q   <= 4'd0;
            idx_q   <= 4'd0;
            fails_q <= 4'd0;
            mis_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            fails_q <= fails_d;
            mis_q   <= mis_d;
            tmr_q   <= tmr_d;
        end
    end

    assign DONE    = (state_q == S_PASS) || (state_q == S_FAIL);
    assign SUCCESS = (state_q == S_PASS);
    assign LOCKED  = (state_q == S_LOCKOUT);
    assign FAILS   = fails_q;

endmodule

// File: tb/tb_code_check_multi.sv
// Randomised bench for code_check_multi against a queue-based model of
// digit entry, failure counting and lockout.
module tb_code_check_multi;

    localparam int KW = 4;
    localparam int ML = 6;
    localparam int MT = 3;
    localparam int LC = 20;

    logic           CLK = 1'b0;
    logic           RST, GO, BPRESS;
    logic [KW-1:0]  BUTTON, ENTER_BUTTON, CLEAR_BUTTON;
    logic [KW*ML-1:0] CORRECT_CODE;
    logic [3:0]     LENGTH;
    logic           DONE, SUCCESS, LOCKED;
    logic [3:0]     FAILS;

    code_check_multi #(.KEY_W(KW), .MAX_LEN(ML), .MAX_TRIES(MT), .LOCK_CYCLES(LC)) dut (
        .CLK(CLK), .RST(RST), .GO(GO), .BUTTON(BUTTON), .BPRESS(BPRESS),
        .CORRECT_CODE(CORRECT_CODE), .LENGTH(LENGTH),
        .ENTER_BUTTON(ENTER_BUTTON), .CLEAR_BUTTON(CLEAR_BUTTON),
        .DONE(DONE), .SUCCESS(SUCCESS), .LOCKED(LOCKED), .FAILS(FAILS)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int m_fails  = 0;
    logic [3:0] keys_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Digits surviving the last clear must equal the first LENGTH code digits.
    function automatic bit model_pass(input logic [23:0] code, input logic [3:0] len);
        logic [3:0] ent[$];
        for (int i = 0; i < keys_q.size() - 1; i++) begin
            if (keys_q[i] == ENTER_BUTTON) break;
            else if (keys_q[i] == CLEAR_BUTTON) ent.delete();
            else ent.push_back(keys_q[i]);
        end
        if (len < 4'd1 || int'(len) > ML) return 1'b0;
        if (ent.size() != int'(len)) return 1'b0;
        for (int i = 0; i < int'(len); i++)
            if (ent[i] != code[i*4 +: 4]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic lockout_wait();
        int cnt = 1;
        GO = 1'b1;
        for (int c = 0; c < 100; c++) begin
            BPRESS = 1'($urandom_range(0, 1));
            BUTTON = 4'($urandom_range(0, 15));
            @(negedge CLK);
            BPRESS = 1'b0;
            if (LOCKED) cnt++;
            else break;
        end
        GO = 1'b0;
        m_fails = 0;
        chk("lock_len", cnt, LC);
        chk("lock_exit_locked", 32'(LOCKED), 0);
        chk("lock_exit_fails", 32'(FAILS), 0);
    endtask

    task automatic attempt(input logic [23:0] code, input logic [3:0] len, input bit arm_press,
                           input bit mutate, input bit noise, input int max_gap, input bit wait_lock);
        bit exp_pass;
        exp_pass = model_pass(code, len);
        CORRECT_CODE = code;
        LENGTH = len;
        GO = 1'b1;
        @(negedge CLK);
        GO = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (mutate) CORRECT_CODE = code ^ (24'($urandom()) | 24'h1);
        if (arm_press) begin
            BPRESS = 1'b1;
            BUTTON = 4'($urandom_range(0, 13));
        end
        @(negedge CLK);
        BPRESS = 1'b0;
        for (int i = 0; i < keys_q.size(); i++) begin
            int gap = (i == 0) ? 0 : $urandom_range(0, max_gap);
            repeat (gap) begin
                chk("busy_done", 32'(DONE), 0);
                @(negedge CLK);
            end
            chk("busy_done", 32'(DONE), 0);
            BUTTON = keys_q[i];
            BPRESS = 1'b1;
            if (noise) GO = 1'($urandom_range(0, 1));
            @(negedge CLK);
            BPRESS = 1'b0;
        end
        GO = 1'b0;
        chk("done_pulse", 32'(DONE), 1);
        chk("success", 32'(SUCCESS), 32'(exp_pass));
        chk("locked_during_done", 32'(LOCKED), 0);
        m_fails = exp_pass ? 0 : ((m_fails >= 15) ? 15 : m_fails + 1);
        @(negedge CLK);
        chk("done_fall", 32'(DONE), 0);
        chk("success_fall", 32'(SUCCESS), 0);
        chk("fails", 32'(FAILS), m_fails);
        chk("locked_rise", 32'(LOCKED), 32'(m_fails >= MT));
        if (m_fails >= MT && wait_lock) lockout_wait();
    endtask

    task automatic rand_keys(input logic [23:0] code, input logic [3:0] len);
        keys_q.delete();
        if ($urandom_range(0, 1) == 1 && int'(len) <= ML) begin
            if ($urandom_range(0, 3) == 0) begin
                keys_q.push_back(4'($urandom_range(0, 13)));
                keys_q.push_back(4'hE);
            end
            for (int i = 0; i < int'(len); i++) keys_q.push_back(code[i*4 +: 4]);
        end else begin
            int n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++)
                keys_q.push_back(($urandom_range(0, 9) == 0) ? 4'hE : 4'($urandom_range(0, 13)));
        end
        keys_q.push_back(4'hF);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_done"}, 32'(DONE), 0);
        chk({tag, "_success"}, 32'(SUCCESS), 0);
        chk({tag, "_locked"}, 32'(LOCKED), 0);
        chk({tag, "_fails"}, 32'(FAILS), 0);
    endtask

    initial begin
        logic [23:0] code;
        logic [3:0]  len;
        RST = 1'b1; GO = 1'b0; BPRESS = 1'b0; BUTTON = '0;
        CORRECT_CODE = '0; LENGTH = '0; ENTER_BUTTON = 4'hF; CLEAR_BUTTON = 4'hE;
        repeat (2) @(negedge CLK);
        check_idle_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};             attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);
        keys_q = '{4'h1, 4'h9, 4'h3, 4'h4, 4'hF};             attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);
        keys_q = '{4'h1, 4'h2, 4'h3, 4'hF};                   attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);
        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};             attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);
        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF};       attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);
        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF};
        attempt(24'h654321, 4'd6, 0, 0, 0, 0, 1);
        keys_q = '{4'hF};                                      attempt(24'h004321, 4'd0, 0, 0, 0, 0, 1);
        keys_q = '{4'h7, 4'h7, 4'hE, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
        attempt(24'h004321, 4'd4, 0, 0, 0, 1, 1);
        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};             attempt(24'h004321, 4'd4, 1, 1, 1, 1, 1);
        keys_q = '{4'hD, 4'h0, 4'h5, 4'h9, 4'hC, 4'h2, 4'hF}; attempt(24'h2C950D, 4'd6, 0, 1, 0, 0, 1);
        CLEAR_BUTTON = 4'hF;
        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};             attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);
        CLEAR_BUTTON = 4'hE;

        for (int a = 0; a < 40; a++) begin
            code = 24'($urandom());
            for (int d = 0; d < ML; d++)
                if (code[d*4 +: 4] >= 4'hE) code[d*4 +: 4] = 4'($urandom_range(0, 13));
            len = 4'($urandom_range(0, 7));
            rand_keys(code, len);
            attempt(code, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 2, 1);
        end

        keys_q = '{4'h1, 4'h9, 4'hF};                          attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);
        CORRECT_CODE = 24'h004321; LENGTH = 4'd4; GO = 1'b1;
        @(negedge CLK); GO = 1'b0;
        @(negedge CLK);
        for (int i = 1; i <= 2; i++) begin
            BUTTON = 4'(i); BPRESS = 1'b1;
            @(negedge CLK);
        end
        BPRESS = 1'b0; RST = 1'b1;
        @(negedge CLK);
        check_idle_outputs("rst_entry");
        RST = 1'b0; m_fails = 0;
        @(negedge CLK);
        chk("rst_entry_no_done", 32'(DONE), 0);
        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};             attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);

        keys_q = '{4'h8, 4'hF};
        for (int i = 0; i < MT; i++) attempt(24'h004321, 4'd4, 0, 0, 0, 0, 0);
        repeat (5) @(negedge CLK);
        chk("mid_lock_locked", 32'(LOCKED), 1);
        RST = 1'b1;
        @(negedge CLK);
        check_idle_outputs("rst_lock");
        RST = 1'b0; m_fails = 0;
        @(negedge CLK);
        chk("rst_lock_no_done", 32'(DONE), 0);
        keys_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};             attempt(24'h004321, 4'd4, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code_check_multi.md
# code_check_multi

Parametrised keypad code checker for the digital-lock datapath. It replaces the fixed 4-bit, 6-digit checker with these changes: configurable key width and maximum code length, a clear key, sticky mismatch tracking, and a consecutive-failure counter with timed lockout. It sits between the debounced keypad encoder (BUTTON/BPRESS) and the lock control FSM, which starts it with GO and consumes DONE/SUCCESS/LOCKED.

## Interface
- KEY_W, 4, bits per key code
- MAX_LEN, 6, maximum digits in a code (1..15)
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..15)
- LOCK_CYCLES, 1000, lockout duration in CLK cycles (>=1)
- CLK  in  1  sole clock, rising edge
- RST  in  1  synchronous, active-high reset
- GO  in  1  start an entry attempt; honoured only in IDLE
- BUTTON  in  KEY_W  key code, valid when BPRESS=1
- BPRESS  in  1  one-cycle key-press strobe
- CORRECT_CODE  in  KEY_W*MAX_LEN  digit i at bits [i*KEY_W +: KEY_W]; digit 0 is entered first
- LENGTH  in  4  number of valid digits in CORRECT_CODE
- ENTER_BUTTON  in  KEY_W  key code meaning "submit"
- CLEAR_BUTTON  in  KEY_W  key code meaning "discard digits entered so far"
- DONE  out  1  one-cycle pulse: attempt finished
- SUCCESS  out  1  high together with DONE when the code matched
- LOCKED  out  1  high throughout lockout
- FAILS  out  4  current consecutive-failure count

## Operation
- States: IDLE, ARM, ENTER, PASS, FAIL, LOCKOUT.
- IDLE:
  - GO=1 latches CORRECT_CODE and LENGTH into internal registers, clears index and the mismatch flag, then goes to ARM.
  - Later changes on the code inputs do not affect this attempt.
- ARM: one cycle; BPRESS is ignored. Then go to ENTER.
- ENTER, on BPRESS with BUTTON:
  - BUTTON==ENTER_BUTTON: go to PASS if mismatch==0, index==latched LENGTH, and 1<=LENGTH<=MAX_LEN. Otherwise go to FAIL.
  - else BUTTON==CLEAR_BUTTON: index<=0, mismatch<=0; stay in ENTER.
  - else digit:
    - If index<MAX_LEN: compare against latched digit[index]. Inequality sets the sticky mismatch flag. Index increments.
    - If index==MAX_LEN: set mismatch; index holds (saturates).
  - Priority: ENTER_BUTTON beats CLEAR_BUTTON if the two parameters are equal.
- PASS: DONE=1, SUCCESS=1 for one cycle; FAILS<=0; go to IDLE.
- FAIL: DONE=1, SUCCESS=0 for one cycle; FAILS<=FAILS+1 (saturating at 15).
  - If the new FAILS>=MAX_TRIES, go to LOCKOUT and load the lock timer with LOCK_CYCLES-1.
  - Otherwise go to IDLE.
- LOCKOUT:
  - LOCKED=1; GO and BPRESS are ignored; the timer decrements each cycle.
  - When the timer reaches 0: FAILS<=0, LOCKED falls, go to IDLE.
- GO outside IDLE is ignored. A digit compared against a latched LENGTH shorter than the index still uses digit[index]; the length check at ENTER rejects such an entry.
- Timer width is $clog2(LOCK_CYCLES). The index register is 4 bits wide.

## Timing
- Reset values: state=IDLE, DONE=0, SUCCESS=0, LOCKED=0, FAILS=0, index=0, mismatch=0, timer=0.
- RST in any state, including mid-entry or lockout, aborts to IDLE on the next edge. No DONE pulse is produced.
- All outputs are registered or decoded directly from state (Moore). No input-to-output combinational path.
- GO sampled at edge t: ARM at t+1; the first accepted key is sampled at edge t+2.
- ENTER press sampled at edge t: DONE/SUCCESS high during cycle t+1 only.
- On a lockout failure: LOCKED rises at t+2 and stays high for exactly LOCK_CYCLES cycles. The first GO is honoured at the edge after LOCKED falls.
- FAILS updates in the same cycle DONE is high (visible at t+2).
- Back-to-back attempts: GO may be asserted in the first IDLE cycle after PASS/FAIL.

## Test plan
- KEY_W=4, MAX_LEN=6, code 1,2,3,4 (CORRECT_CODE=24'h004321, LENGTH=4), ENTER_BUTTON=4'hF, CLEAR_BUTTON=4'hE. GO, keys 1,2,3,4,F -> DONE=SUCCESS=1 for one cycle, FAILS=0.
- Same setup, keys 1,9,3,4,F -> DONE=1, SUCCESS=0, FAILS=1. Keys 1,2,3,F (short) -> FAILS=2. Keys 1,2,3,4,5,F (long) -> fail.
- Clear key: keys 7,7,E,1,2,3,4,F -> SUCCESS. Key pressed in the ARM cycle is ignored; the remaining keys 1,2,3,4,F -> SUCCESS.
- MAX_TRIES=3, LOCK_CYCLES=20: three wrong attempts -> LOCKED high exactly 20 cycles, and GO during lockout is ignored. Afterwards FAILS=0 and a correct entry succeeds. A correct entry after two failures resets FAILS to 0.
- Overflow and invalid length: press 7 digits with MAX_LEN=6 -> index saturates, fail. LENGTH=0 with a bare F -> fail.
- RST mid-entry (after 2 digits) and mid-lockout -> next cycle IDLE, all outputs 0, no DONE. Changing CORRECT_CODE after GO does not alter the result.
